// File: rtl/dpram_arb_pkg.sv
// dpram_arb_pkg: shared constants, pick type and rotate-and-find-first helper for the RAM port arbiter
package dpram_arb_pkg;
  localparam int MAX_NREQ = 8;
  localparam int IDX_W = 3;
  localparam int TAG_W = MAX_NREQ;
  typedef struct packed {
    logic found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;
  // Scans downward so the lowest offset from ptr is written last and wins
  function automatic rr_pick_t rr_find(input logic [MAX_NREQ-1:0] vld, input logic [IDX_W-1:0] ptr, input int n);
    rr_pick_t r;
    logic [IDX_W-1:0] j;
    r = '0;
    for (int k = MAX_NREQ - 1; k >= 0; k--) begin
      j = IDX_W'((int'(ptr) + k) % n);
      if (k < n && vld[j]) r = '{found: 1'b1, idx: j};
    end
    return r;
  endfunction
endpackage

// File: rtl/dpram_arb_rr.sv
// dpram_arb_rr: combinational rotating priority encoder with one-hot grant and binary index
module dpram_arb_rr
  import dpram_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  vld,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  rr_pick_t p;
  assign p = rr_find(MAX_NREQ'(vld), ptr, NREQ);
  assign found = p.found;
  assign idx = p.idx;
  assign gnt = p.found ? NREQ'(1) << p.idx : '0;
endmodule

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: round-robin sharing of one RAM port with registered command and tagged read return
// DPRAM_ARB_PRIO0_EN: requester 0 gets fixed top priority; the rest rotate.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW = 4,
  parameter int DW = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ-1:0]  req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic [AW-1:0]    ram_addr,
  output logic             ram_we,
  output logic [DW-1:0]    ram_wdata,
  input  logic [DW-1:0]    ram_q
);
  logic [IDX_W-1:0] ptr, rr_idx;
  logic [NREQ-1:0] rr_vld, rr_gnt, push;
  logic rr_found, move;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [NREQ-1:0] tag [RD_LATENCY+1];
`ifdef DPRAM_ARB_PRIO0_EN
  assign rr_vld = {req_valid[NREQ-1:1], 1'b0};
  assign req_ready = req_valid[0] ? NREQ'(1) : rr_gnt;
  assign move = rr_found & ~req_valid[0];
`else
  assign rr_vld = req_valid;
  assign req_ready = rr_gnt;
  assign move = rr_found;
`endif
  dpram_arb_rr #(.NREQ(NREQ)) u_rr (
    .vld  (rr_vld),
    .ptr  (ptr),
    .gnt  (rr_gnt),
    .idx  (rr_idx),
    .found(rr_found)
  );
  // Reads carry a one-hot tag so the response can be routed back; writes carry zero
  assign push = req_ready & ~req_we;
  always_comb begin
    sel_addr = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
  end
  always_ff @(posedge clk)
    if (rst) begin
      ptr <= '0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) tag[i] <= '0;
    end else begin
      ram_we <= |(req_ready & req_we);
      if (|req_ready) begin
        ram_addr <= sel_addr;
        ram_wdata <= sel_wdata;
      end
      if (move) ptr <= (rr_idx == IDX_W'(NREQ - 1)) ? '0 : rr_idx + 1'b1;
      tag[0] <= push;
      for (int i = 1; i <= RD_LATENCY; i++) tag[i] <= tag[i-1];
    end
  assign rsp_valid = tag[RD_LATENCY];
  assign rsp_rdata = ram_q;
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter: directed and random checks of dpram_port_arbiter against an acceptance-order model
module tb_dpram_port_arbiter;
  localparam int N = 4;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int RL = 1;
`ifdef DPRAM_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, ram_wdata, ram_q;
  logic [AW-1:0] ram_addr;
  logic ram_we;
  always #5 clk = ~clk;
  dpram_port_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .RD_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q)
  );
  // RAM environment: read-first, one cycle clock-to-Q
  logic [DW-1:0] ram [16];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_q <= ram[ram_addr];
  end
  logic [AW-1:0] ta [N];
  logic [DW-1:0] td [N];
  int vecs = 0, misc = 0, cyc_n = 0, mptr = 0, last_w = -1;
  logic [DW-1:0] mm [16];
  logic mwe = 1'b0;
  logic [AW-1:0] maddr = '0;
  logic [DW-1:0] mwd = '0;
  logic [N-1:0] due_v [4096];
  logic [DW-1:0] due_d [4096];
  logic [N-1:0] er;

  function automatic int pick(input logic [N-1:0] v, input int p);
    if (PRIO && v[0]) return 0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (v[j] && !(PRIO && j == 0)) return j;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      misc++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = ta[i];
      req_wdata[i*DW +: DW] = td[i];
    end
  endtask

  task automatic setreq(input int i, input logic we, input int a, input int d);
    req_valid[i] = 1'b1;
    req_we[i] = we;
    ta[i] = AW'(a);
    td[i] = DW'(d);
  endtask

  // One clock: check outputs against model, then advance the model across the edge
  task automatic cyc();
    int w, s;
    logic [N-1:0] e;
    pack();
    #1;
    w = pick(req_valid, mptr);
    e = (w < 0) ? '0 : N'(1) << w;
    s = cyc_n % 4096;
    chk("req_ready", 32'(req_ready), 32'(e));
    chk("ram_we", 32'(ram_we), 32'(mwe));
    chk("ram_addr", 32'(ram_addr), 32'(maddr));
    chk("ram_wdata", 32'(ram_wdata), 32'(mwd));
    chk("rsp_valid", 32'(rsp_valid), 32'(due_v[s]));
    if (due_v[s] != '0) chk("rsp_rdata", 32'(rsp_rdata), 32'(due_d[s]));
    due_v[s] = '0;
    if (rst) begin
      mptr = 0;
      mwe = 1'b0;
      maddr = '0;
      mwd = '0;
      last_w = -1;
      for (int k = 0; k < 4096; k++) due_v[k] = '0;
    end else begin
      last_w = w;
      mwe = 1'b0;
      if (w >= 0) begin
        maddr = ta[w];
        mwd = td[w];
        mwe = req_we[w];
        if (req_we[w]) mm[ta[w]] = td[w];
        else begin
          due_v[(cyc_n + 1 + RL) % 4096] = e;
          due_d[(cyc_n + 1 + RL) % 4096] = mm[ta[w]];
        end
        if (!(PRIO && w == 0)) mptr = (w + 1) % N;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_we = '0;
    for (int i = 0; i < N; i++) begin
      ta[i] = '0;
      td[i] = '0;
    end
    for (int i = 0; i < 16; i++) begin
      ram[i] = '0;
      mm[i] = '0;
    end
    for (int k = 0; k < 4096; k++) due_v[k] = '0;
    pack();
    @(negedge clk);
    @(negedge clk);
    cyc();
    rst = 1'b0;
    // write 0xA5 to addr 3 via req 1, read it back via req 2
    setreq(1, 1'b1, 3, 'hA5);
    cyc();
    req_valid = '0;
    setreq(2, 1'b0, 3, 0);
    cyc();
    req_valid = '0;
    pack();
    #1;
    chk("wr_we", 32'(ram_we), 32'd0);
    chk("rd_addr", 32'(ram_addr), 32'd3);
    cyc();
    #1;
    chk("rd_rsp_v", 32'(rsp_valid), 32'h4);
    chk("rd_rsp_d", 32'(rsp_rdata), 32'hA5);
    cyc();
    // all four continuously valid from reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) setreq(i, 1'b0, i, 0);
      pack();
      #1;
      er = N'(1) << (k % N);
      chk("rr_order", 32'(req_ready), 32'(er));
      cyc();
    end
    // only requesters 1 and 3
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      setreq(1, 1'b1, 8 + k, 'h30 + k);
      setreq(3, 1'b0, 8, 0);
      cyc();
    end
    // preload then back-to-back reads by 0,1,2
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      req_valid = '0;
      setreq(0, 1'b1, k, 'h10 + k);
      cyc();
    end
    for (int k = 0; k < 3; k++) begin
      req_valid = '0;
      setreq(k, 1'b0, k, 0);
      cyc();
    end
    req_valid = '0;
    cyc();
    cyc();
    // reset one cycle after a read accept drops the response
    setreq(1, 1'b0, 2, 0);
    cyc();
    req_valid = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    pack();
    #1;
    chk("rst_rsp_v", 32'(rsp_valid), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    cyc();
    cyc();
`ifdef DPRAM_ARB_PRIO0_EN
    for (int k = 0; k < 4; k++) begin
      setreq(0, 1'b0, 1, 0);
      setreq(2, 1'b0, 2, 0);
      cyc();
    end
    req_valid[0] = 1'b0;
    pack();
    #1;
    chk("prio_drop", 32'(req_ready), 32'h4);
    cyc();
    req_valid = '0;
    cyc();
    cyc();
`endif
    // random traffic, requests held until accepted
    req_valid = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          setreq(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
      rst = ($urandom_range(0, 299) == 0);
      cyc();
      if (last_w >= 0) req_valid[last_w] = 1'b0;
    end
    rst = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 4; k++) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, misc);
    $finish;
  end
endmodule
